// File: rtl/piano_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : piano_pkg
//  Description : Mode codes, mode FSM state type and debounce default shared
//                by the button front-end and the display/LED/speaker selector.
//  Revision    : 1.0  initial release
// ============================================================================
package piano_pkg;

    // Mode codes decoded by the selector
    localparam logic [2:0] MODE_IDLE   = 3'b000;
    localparam logic [2:0] MODE_AUTO   = 3'b011;
    localparam logic [2:0] MODE_MANUAL = 3'b001;
    localparam logic [2:0] MODE_LEARN  = 3'b111;

    // 20 ms at 100 MHz
    localparam int unsigned DEB_CYCLES_DEFAULT = 2000000;

    // State values equal the mode codes so the state register drives `mode` directly
    typedef enum logic [2:0] {
        ST_IDLE   = MODE_IDLE,
        ST_AUTO   = MODE_AUTO,
        ST_MANUAL = MODE_MANUAL,
        ST_LEARN  = MODE_LEARN
    } mode_state_e;

    // Successor of a state on a mode-button press
    function automatic mode_state_e next_mode(input mode_state_e s);
        mode_state_e n;
        case (s)
            ST_IDLE:   n = ST_AUTO;
            ST_AUTO:   n = ST_MANUAL;
            ST_MANUAL: n = ST_LEARN;
            default:   n = ST_IDLE;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mode_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Two-flop synchroniser, stability counter, debounced level
//                and one-cycle press pulse on a debounced 0->1 transition.
//  Revision    : 1.0  initial release
// ============================================================================
module btn_debounce
    import piano_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned     CNT_W    = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             level_prev_q;

    // Count consecutive samples disagreeing with the debounced level; toggle after DEB_CYCLES of them
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = ~level_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Synchroniser, counter and level registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
        end
    end

    assign press = level_q & ~level_prev_q;

endmodule
`default_nettype wire

// File: rtl/mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mode_ctrl
//  Description : Debounces four buttons and drives the mode FSM, the song
//                counter and the mode/song change and stop-request strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module mode_ctrl
    import piano_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int unsigned SONG_MAX   = 3
) (
    input  logic       clk,
    input  logic       rst_n,      // active-high synchronous reset; name kept for board compatibility
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_back,
    input  logic       play_busy,
    output logic [2:0] mode,
    output logic [1:0] song_num,
    output logic       mode_chg,
    output logic       song_chg,
    output logic       stop_req
);

    localparam logic [1:0] SONG_LAST = 2'(SONG_MAX);

    logic        ev_mode;
    logic        ev_up;
    logic        ev_down;
    logic        ev_back;

    mode_state_e state_q;
    mode_state_e state_d;
    logic [1:0]  song_q;
    logic [1:0]  song_d;
    logic        mode_pend_q;
    logic        mode_pend_d;
    logic        song_pend_q;
    logic        song_pend_d;
    logic        stop_pend_q;
    logic        stop_pend_d;
    logic        mode_chg_q;
    logic        song_chg_q;
    logic        stop_req_q;
    logic        w_playing;
    logic        w_song_ok;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk(clk), .rst(rst_n), .btn_raw(btn_mode), .press(ev_mode)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk(clk), .rst(rst_n), .btn_raw(btn_up), .press(ev_up)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
        .clk(clk), .rst(rst_n), .btn_raw(btn_down), .press(ev_down)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_back (
        .clk(clk), .rst(rst_n), .btn_raw(btn_back), .press(ev_back)
    );

    // Act on the single highest-priority event (back > mode > up > down); the rest are dropped
    always_comb begin
        state_d     = state_q;
        song_d      = song_q;
        mode_pend_d = 1'b0;
        song_pend_d = 1'b0;
        stop_pend_d = 1'b0;
        w_playing   = (state_q == ST_AUTO) || (state_q == ST_LEARN);
        w_song_ok   = w_playing && !play_busy;
        if (ev_back) begin
            if (state_q != ST_IDLE) begin
                state_d     = ST_IDLE;
                mode_pend_d = 1'b1;
                stop_pend_d = w_playing && play_busy;
            end
        end else if (ev_mode) begin
            state_d     = next_mode(state_q);
            mode_pend_d = 1'b1;
            stop_pend_d = w_playing && play_busy;
        end else if (ev_up) begin
            if (w_song_ok) begin
                song_d      = (song_q == SONG_LAST) ? 2'd0 : song_q + 2'd1;
                song_pend_d = (song_d != song_q);
            end
        end else if (ev_down) begin
            if (w_song_ok) begin
                song_d      = (song_q == 2'd0) ? SONG_LAST : song_q - 2'd1;
                song_pend_d = (song_d != song_q);
            end
        end
    end

    // Mode FSM, song counter and strobes; strobes trail the value change by one cycle
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= ST_IDLE;
            song_q      <= 2'd0;
            mode_pend_q <= 1'b0;
            song_pend_q <= 1'b0;
            stop_pend_q <= 1'b0;
            mode_chg_q  <= 1'b0;
            song_chg_q  <= 1'b0;
            stop_req_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            song_q      <= song_d;
            mode_pend_q <= mode_pend_d;
            song_pend_q <= song_pend_d;
            stop_pend_q <= stop_pend_d;
            mode_chg_q  <= mode_pend_q;
            song_chg_q  <= song_pend_q;
            stop_req_q  <= stop_pend_q;
        end
    end

    assign mode     = state_q;
    assign song_num = song_q;
    assign mode_chg = mode_chg_q;
    assign song_chg = song_chg_q;
    assign stop_req = stop_req_q;

endmodule
`default_nettype wire

// File: tb/tb_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mode_ctrl
//  Description : Directed and random stimulus for mode_ctrl compared every
//                cycle against a window-based behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mode_ctrl;

    localparam int DEB  = 4;
    localparam int SMAX = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_mode, btn_up, btn_down, btn_back, play_busy;
    logic [2:0] mode;
    logic [1:0] song_num;
    logic       mode_chg, song_chg, stop_req;

    always #5 clk = ~clk;

    mode_ctrl #(.DEB_CYCLES(DEB), .SONG_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down), .btn_back(btn_back),
        .play_busy(play_busy),
        .mode(mode), .song_num(song_num),
        .mode_chg(mode_chg), .song_chg(song_chg), .stop_req(stop_req)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model state. Button index: 0 back, 1 mode, 2 up, 3 down.
    logic [2:0] codes [4] = '{3'b000, 3'b011, 3'b001, 3'b111};
    bit  hist [4][DEB+2];   // hist[b][k] = raw level k edges ago
    bit  lvl  [4];
    bit  ev   [4];
    int  m_idx;             // position in IDLE, AUTO, MANUAL, LEARN cycle
    int  m_song;
    bit  m_mchg, m_schg, m_stop, p_mchg, p_schg, p_stop;

    task automatic model_edge(input bit r, input logic [3:0] raw, input bit busy);
        bit playing;
        bit all_diff;
        int old;
        if (r) begin
            for (int b = 0; b < 4; b++) begin
                for (int k = 0; k < DEB + 2; k++) hist[b][k] = 1'b0;
                lvl[b] = 1'b0;
                ev[b]  = 1'b0;
            end
            m_idx = 0; m_song = 0;
            m_mchg = 0; m_schg = 0; m_stop = 0;
            p_mchg = 0; p_schg = 0; p_stop = 0;
            return;
        end
        m_mchg = p_mchg; m_schg = p_schg; m_stop = p_stop;
        p_mchg = 0; p_schg = 0; p_stop = 0;
        playing = (m_idx == 1) || (m_idx == 3);
        if (ev[0]) begin
            if (m_idx != 0) begin
                p_stop = playing && busy;
                m_idx  = 0;
                p_mchg = 1;
            end
        end else if (ev[1]) begin
            p_stop = playing && busy;
            m_idx  = (m_idx + 1) % 4;
            p_mchg = 1;
        end else if (ev[2] || ev[3]) begin
            if (playing && !busy) begin
                old    = m_song;
                m_song = ev[2] ? (m_song + 1) % (SMAX + 1) : (m_song + SMAX) % (SMAX + 1);
                p_schg = (m_song != old);
            end
        end
        // A level flips once the DEB synchronised samples before it all disagree with it
        for (int b = 0; b < 4; b++) begin
            for (int k = DEB + 1; k > 0; k--) hist[b][k] = hist[b][k-1];
            hist[b][0] = raw[b];
            all_diff = 1'b1;
            for (int k = 2; k <= DEB + 1; k++) if (hist[b][k] == lvl[b]) all_diff = 1'b0;
            ev[b] = 1'b0;
            if (all_diff) begin
                lvl[b] = ~lvl[b];
                ev[b]  = lvl[b];
            end
        end
    endtask

    task automatic step(input bit r, input logic [3:0] b, input bit busy);
        rst_n     = r;
        btn_back  = b[0];
        btn_mode  = b[1];
        btn_up    = b[2];
        btn_down  = b[3];
        play_busy = busy;
        @(posedge clk);
        model_edge(r, b, busy);
        #1;
        vectors++;
        assert (mode === codes[m_idx]) else begin
            miscompares++;
            $error("FAIL mode: got %b expected %b at %0t", mode, codes[m_idx], $time);
        end
        assert (song_num === 2'(m_song)) else begin
            miscompares++;
            $error("FAIL song_num: got %0d expected %0d at %0t", song_num, m_song, $time);
        end
        assert (mode_chg === m_mchg) else begin
            miscompares++;
            $error("FAIL mode_chg: got %b expected %b at %0t", mode_chg, m_mchg, $time);
        end
        assert (song_chg === m_schg) else begin
            miscompares++;
            $error("FAIL song_chg: got %b expected %b at %0t", song_chg, m_schg, $time);
        end
        assert (stop_req === m_stop) else begin
            miscompares++;
            $error("FAIL stop_req: got %b expected %b at %0t", stop_req, m_stop, $time);
        end
    endtask

    task automatic press(input logic [3:0] b, input int hold, input int gap, input bit busy);
        for (int i = 0; i < hold; i++) step(1'b0, b, busy);
        for (int i = 0; i < gap; i++)  step(1'b0, 4'b0000, busy);
    endtask

    initial begin
        logic [3:0] rb;
        int         len;
        bit         rbusy;
        bit         rr;

        // Reset, then quiet
        for (int i = 0; i < 3; i++)  step(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 4'b0000, 1'b0);

        // Four mode presses: AUTO, MANUAL, LEARN, IDLE
        for (int i = 0; i < 4; i++) press(4'b0010, 10, 10, 1'b0);

        // Bouncing mode button never settles
        for (int i = 0; i < 20; i++) step(1'b0, ((i / 2) % 2) ? 4'b0010 : 4'b0000, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 4'b0000, 1'b0);

        // AUTO, idle player: down wraps to 3, then up twice
        press(4'b0010, 10, 10, 1'b0);
        press(4'b1000, 10, 10, 1'b0);
        press(4'b0100, 10, 10, 1'b0);
        press(4'b0100, 10, 10, 1'b0);

        // AUTO, busy player: up ignored, back raises stop_req
        press(4'b0100, 10, 10, 1'b1);
        press(4'b0001, 10, 10, 1'b1);

        // MANUAL, back and mode together: back wins
        press(4'b0010, 10, 10, 1'b0);
        press(4'b0010, 10, 10, 1'b0);
        press(4'b0011, 10, 10, 1'b0);

        // Reset in the middle of an up debounce
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0100, 1'b0);
        step(1'b1, 4'b0100, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b0, 4'b0000, 1'b0);

        // Mode button held through reset
        for (int i = 0; i < 2; i++)  step(1'b1, 4'b0010, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 4'b0010, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 4'b0000, 1'b0);

        // Random segments of held levels, random busy, occasional reset
        for (int s = 0; s < 400; s++) begin
            for (int b = 0; b < 4; b++) rb[b] = ($urandom_range(0, 3) == 0);
            len   = $urandom_range(1, 12);
            rbusy = ($urandom_range(0, 2) == 0);
            rr    = ($urandom_range(0, 59) == 0);
            if (rr) step(1'b1, rb, rbusy);
            for (int i = 0; i < len; i++) step(1'b0, rb, rbusy);
        end
        for (int i = 0; i < 12; i++) step(1'b0, 4'b0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
